// File: rtl/shutdown_supervisor.sv
// Multi-channel shutdown supervisor: debounced sticky per-channel shut-off flags,
// cooldown-then-acknowledge release, gated keep_driving and a saturating trip counter.
module shutdown_supervisor #(
   parameter int N_CH     = 4,
   parameter int DEBOUNCE = 3,
   parameter int COOLDOWN = 4
) (
   input  logic            clk,
   input  logic            areset,
   input  logic [N_CH-1:0] cpu_overheated,
   input  logic            clear,
   input  logic            arrived,
   input  logic            gas_tank_empty,
   output logic [N_CH-1:0] shut_off_computer,
   output logic            any_shutoff,
   output logic            keep_driving,
   output logic [7:0]      trip_count
);

   localparam int CNT_MAX = (DEBOUNCE > COOLDOWN) ? DEBOUNCE : COOLDOWN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W:0]   DEB_V   = (CNT_W + 1)'(DEBOUNCE);
   localparam logic [CNT_W:0]   COOL_V  = (CNT_W + 1)'(COOLDOWN);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_OK    = 3'd0,
      ST_PEND  = 3'd1,
      ST_TRIP  = 3'd2,
      ST_COOL  = 3'd3,
      ST_READY = 3'd4
   } ch_state_t;

   ch_state_t        state_p0  [N_CH];
   ch_state_t        state_nxt [N_CH];
   logic [CNT_W-1:0] cnt_p0    [N_CH];
   logic [CNT_W-1:0] cnt_nxt   [N_CH];
   logic [N_CH-1:0]  new_trip;
   logic [N_CH-1:0]  shut_off_nxt;
   logic [N_CH-1:0]  shut_off_p0;
   logic [4:0]       n_new;
   logic [7:0]       trip_count_p0;

   function automatic logic [7:0] sat8(input logic [8:0] s);
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   // Next-state: per-channel FSM and count of channels newly tripping this edge
   always_comb begin
      logic [CNT_W:0] cnt_inc;
      n_new        = '0;
      new_trip     = '0;
      shut_off_nxt = '0;
      cnt_inc      = '0;
      for (int i = 0; i < N_CH; i++) begin
         state_nxt[i] = state_p0[i];
         cnt_nxt[i]   = cnt_p0[i];
         cnt_inc      = {1'b0, cnt_p0[i]} + {{CNT_W{1'b0}}, 1'b1};
         case (state_p0[i])
            ST_OK: begin
               if (cpu_overheated[i]) begin
                  if (DEBOUNCE == 1) begin
                     state_nxt[i] = ST_TRIP;
                     new_trip[i]  = 1'b1;
                     cnt_nxt[i]   = '0;
                  end else begin
                     state_nxt[i] = ST_PEND;
                     cnt_nxt[i]   = CNT_ONE;
                  end
               end
            end
            ST_PEND: begin
               if (!cpu_overheated[i]) begin
                  state_nxt[i] = ST_OK;
                  cnt_nxt[i]   = '0;
               end else if (cnt_inc == DEB_V) begin
                  state_nxt[i] = ST_TRIP;
                  new_trip[i]  = 1'b1;
                  cnt_nxt[i]   = '0;
               end else begin
                  cnt_nxt[i] = cnt_inc[CNT_W-1:0];
               end
            end
            ST_TRIP: begin
               if (!cpu_overheated[i]) begin
                  if (COOLDOWN == 1) begin
                     state_nxt[i] = ST_READY;
                     cnt_nxt[i]   = '0;
                  end else begin
                     state_nxt[i] = ST_COOL;
                     cnt_nxt[i]   = CNT_ONE;
                  end
               end
            end
            ST_COOL: begin
               if (cpu_overheated[i]) begin
                  state_nxt[i] = ST_TRIP;
                  cnt_nxt[i]   = '0;
               end else if (cnt_inc == COOL_V) begin
                  state_nxt[i] = ST_READY;
                  cnt_nxt[i]   = '0;
               end else begin
                  cnt_nxt[i] = cnt_inc[CNT_W-1:0];
               end
            end
            ST_READY: begin
               // A fresh overheat wins over a simultaneous acknowledge
               if (cpu_overheated[i]) begin
                  state_nxt[i] = ST_TRIP;
                  cnt_nxt[i]   = '0;
               end else if (clear) begin
                  state_nxt[i] = ST_OK;
                  cnt_nxt[i]   = '0;
               end
            end
            default: begin
               state_nxt[i] = ST_OK;
               cnt_nxt[i]   = '0;
            end
         endcase
         shut_off_nxt[i] = (state_nxt[i] == ST_TRIP) || (state_nxt[i] == ST_COOL) ||
                           (state_nxt[i] == ST_READY);
         n_new = n_new + {4'b0000, new_trip[i]};
      end
   end

   // State register stage: channel state, counters, flags and trip counter
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < N_CH; i++) begin
            state_p0[i] <= ST_OK;
            cnt_p0[i]   <= '0;
         end
         shut_off_p0   <= '0;
         trip_count_p0 <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_p0[i] <= state_nxt[i];
            cnt_p0[i]   <= cnt_nxt[i];
         end
         shut_off_p0   <= shut_off_nxt;
         trip_count_p0 <= sat8({1'b0, trip_count_p0} + {4'b0000, n_new});
      end
   end

   // Output decode
   always_comb begin
      any_shutoff  = |shut_off_p0;
      keep_driving = ~arrived & ~gas_tank_empty & ~any_shutoff;
   end

   assign shut_off_computer = shut_off_p0;
   assign trip_count        = trip_count_p0;

endmodule

// File: tb/tb_shutdown_supervisor.sv
// Scoreboard bench for shutdown_supervisor (N_CH=4, DEBOUNCE=3, COOLDOWN=4).
module tb_shutdown_supervisor;

   logic       clk = 1'b0;
   logic       areset;
   logic [3:0] cpu_overheated;
   logic       clear;
   logic       arrived;
   logic       gas_tank_empty;
   logic [3:0] shut_off_computer;
   logic       any_shutoff;
   logic       keep_driving;
   logic [7:0] trip_count;

   typedef struct {
      logic [3:0] so;
      logic [7:0] tc;
      logic       kd;
      string      nm;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   event sample_ev;
   bit   stim_done = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   m_tc;

   shutdown_supervisor #(.N_CH(4), .DEBOUNCE(3), .COOLDOWN(4)) dut (
      .clk(clk), .areset(areset), .cpu_overheated(cpu_overheated), .clear(clear),
      .arrived(arrived), .gas_tank_empty(gas_tank_empty),
      .shut_off_computer(shut_off_computer), .any_shutoff(any_shutoff),
      .keep_driving(keep_driving), .trip_count(trip_count)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [3:0] eso, input logic [7:0] etc, input string nm);
      exp_t x;
      x.so = eso;
      x.tc = etc;
      x.kd = ~arrived & ~gas_tank_empty & ~(|eso);
      x.nm = nm;
      sb.push_back(x);
      -> sample_ev;
   endtask

   task automatic cyc4(input logic [3:0] ov, input logic clr, input logic arr, input logic emp,
                       input logic [3:0] eso, input logic [7:0] etc, input string nm);
      @(negedge clk);
      cpu_overheated = ov;
      clear          = clr;
      arrived        = arr;
      gas_tank_empty = emp;
      @(posedge clk);
      push(eso, etc, nm);
   endtask

   task automatic cyc(input logic [3:0] ov, input logic clr,
                      input logic [3:0] eso, input logic [7:0] etc, input string nm);
      cyc4(ov, clr, 1'b0, 1'b0, eso, etc, nm);
   endtask

   // Monitor: pops one expectation per sample event and compares
   initial begin
      forever begin
         @(sample_ev);
         #1;
         if (stim_done) begin
            total++;
            if (sb.size() != 0) begin
               bad++;
               $display("FAIL drain pending=%0d required=0", sb.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end else if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty sample with no expectation");
         end else begin
            e = sb.pop_front();
            total++;
            if (shut_off_computer !== e.so) begin
               bad++;
               $display("FAIL %s shut_off actual=%b required=%b", e.nm, shut_off_computer, e.so);
            end
            total++;
            if (any_shutoff !== (|e.so)) begin
               bad++;
               $display("FAIL %s any_shutoff actual=%b required=%b", e.nm, any_shutoff, |e.so);
            end
            total++;
            if (trip_count !== e.tc) begin
               bad++;
               $display("FAIL %s trip_count actual=%0d required=%0d", e.nm, trip_count, e.tc);
            end
            total++;
            if (keep_driving !== e.kd) begin
               bad++;
               $display("FAIL %s keep_driving actual=%b required=%b", e.nm, keep_driving, e.kd);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      areset = 1'b1; cpu_overheated = '0; clear = 1'b0; arrived = 1'b0; gas_tank_empty = 1'b0;
      #2;
      push(4'b0000, 8'd0, "reset_state");
      @(negedge clk);
      areset = 1'b0;

      // Async reset from TRIP with trip_count=1
      cyc(4'b0001, 1'b0, 4'b0000, 8'd0, "t1_pend1");
      cyc(4'b0001, 1'b0, 4'b0000, 8'd0, "t1_pend2");
      cyc(4'b0001, 1'b0, 4'b0001, 8'd1, "t1_trip");
      @(negedge clk);
      #2;
      cpu_overheated = '0;
      areset = 1'b1;
      push(4'b0000, 8'd0, "t1_async_rst");
      @(negedge clk);
      areset = 1'b0;
      cyc(4'b0000, 1'b0, 4'b0000, 8'd0, "t1_post_rst");

      // Debounce
      cyc(4'b0001, 1'b0, 4'b0000, 8'd0, "t2_hi1");
      cyc(4'b0001, 1'b0, 4'b0000, 8'd0, "t2_hi2");
      cyc(4'b0000, 1'b0, 4'b0000, 8'd0, "t2_lo");
      cyc(4'b0001, 1'b0, 4'b0000, 8'd0, "t2_hi1b");
      cyc(4'b0001, 1'b0, 4'b0000, 8'd0, "t2_hi2b");
      cyc(4'b0001, 1'b0, 4'b0001, 8'd1, "t2_trip");

      // Cooldown interrupted, clear ignored while cooling
      cyc(4'b0000, 1'b1, 4'b0001, 8'd1, "t3_cool1");
      cyc(4'b0000, 1'b1, 4'b0001, 8'd1, "t3_cool2");
      cyc(4'b0000, 1'b1, 4'b0001, 8'd1, "t3_cool3");
      cyc(4'b0001, 1'b1, 4'b0001, 8'd1, "t3_retrip");
      cyc(4'b0000, 1'b0, 4'b0001, 8'd1, "t3_c1");
      cyc(4'b0000, 1'b0, 4'b0001, 8'd1, "t3_c2");
      cyc(4'b0000, 1'b0, 4'b0001, 8'd1, "t3_c3");
      cyc(4'b0000, 1'b0, 4'b0001, 8'd1, "t3_ready");
      cyc(4'b0000, 1'b0, 4'b0001, 8'd1, "t3_ready_hold");
      cyc(4'b0000, 1'b1, 4'b0000, 8'd1, "t3_clear");

      // Simultaneous trips and READY retrip vs clear
      cyc(4'b0110, 1'b0, 4'b0000, 8'd1, "t4_p1");
      cyc(4'b0110, 1'b0, 4'b0000, 8'd1, "t4_p2");
      cyc(4'b0110, 1'b0, 4'b0110, 8'd3, "t4_trip2");
      for (int k = 0; k < 4; k++) cyc(4'b0000, 1'b0, 4'b0110, 8'd3, "t4_cool");
      cyc(4'b0010, 1'b1, 4'b0010, 8'd3, "t4_retrip_clear");
      for (int k = 0; k < 4; k++) cyc(4'b0000, 1'b0, 4'b0010, 8'd3, "t4_cool_ch1");
      cyc(4'b0000, 1'b1, 4'b0000, 8'd3, "t4_clear_ch1");

      // keep_driving gating
      cyc(4'b0000, 1'b0, 4'b0000, 8'd3, "t5_drive");
      cyc(4'b1000, 1'b0, 4'b0000, 8'd3, "t5_p1");
      cyc(4'b1000, 1'b0, 4'b0000, 8'd3, "t5_p2");
      cyc(4'b1000, 1'b0, 4'b1000, 8'd4, "t5_trip3");
      for (int k = 0; k < 4; k++) cyc(4'b0000, 1'b0, 4'b1000, 8'd4, "t5_cool");
      cyc(4'b0000, 1'b1, 4'b0000, 8'd4, "t5_clear3");
      cyc4(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 8'd4, "t5_arrived");
      cyc4(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 8'd4, "t5_empty");
      cyc4(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'd4, "t5_resume");

      // Saturation: 130 rounds of two simultaneous new trips
      m_tc = 4;
      for (int r = 0; r < 130; r++) begin
         cyc(4'b0011, 1'b0, 4'b0000, 8'(m_tc), "t6_p1");
         cyc(4'b0011, 1'b0, 4'b0000, 8'(m_tc), "t6_p2");
         m_tc = (m_tc + 2 > 255) ? 255 : m_tc + 2;
         cyc(4'b0011, 1'b0, 4'b0011, 8'(m_tc), "t6_trip");
         for (int k = 0; k < 4; k++) cyc(4'b0000, 1'b0, 4'b0011, 8'(m_tc), "t6_cool");
         cyc(4'b0000, 1'b1, 4'b0000, 8'(m_tc), "t6_clear");
      end
      cyc(4'b0000, 1'b0, 4'b0000, 8'd255, "t6_hold");

      @(negedge clk);
      stim_done = 1'b1;
      -> sample_ev;
   end

endmodule
